// File: rtl/mem_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and load/store,
// one transaction in flight, round-robin on contention, with a response timeout.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no transaction; grant a requester and latch its fields
// S_ISSUE | present the latched request downstream until accepted
// S_WAIT  | wait for the response; timer forces an error response
// S_RESP  | one-cycle response strobe to the owning requester
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hdeadbeef
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_rsp_valid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_rsp_valid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    // Down-counter loaded on entry to S_WAIT; terminal count 0 equals
    // TIMEOUT_CYCLES-1 elapsed wait cycles.
    localparam logic [15:0] CNT_LOAD = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic        last_ifu;
    logic        own_lsu;
    logic [31:0] addr_q;
    logic        wen_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic [15:0] cnt;
    logic        grant_ifu;
    logic        grant_lsu;
    logic        wait_done;
    logic [31:0] rsp_data;

    // Reset value of last_ifu (0) means the last grant went to LSU.
    always_comb begin
        grant_lsu = lsu_req_valid && (!ifu_req_valid || last_ifu);
        grant_ifu = ifu_req_valid && !grant_lsu;
        wait_done = mem_rsp_valid || (cnt == 16'd0);
        if (wen_q)
            rsp_data = 32'd0;
        else if (mem_rsp_valid)
            rsp_data = mem_rdata;
        else
            rsp_data = ERR_RDATA;
    end

    always_comb begin
        state_nxt     = state;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        mem_addr      = 32'd0;
        mem_wen       = 1'b0;
        mem_wdata     = 32'd0;
        mem_wmask     = 4'd0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                ifu_req_ready = grant_ifu && !rst;
                lsu_req_ready = grant_lsu && !rst;
                if (grant_ifu || grant_lsu)
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                mem_req_valid = 1'b1;
                mem_addr      = addr_q;
                mem_wen       = wen_q;
                mem_wdata     = wdata_q;
                mem_wmask     = wmask_q;
                if (mem_req_ready)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (wait_done)
                    state_nxt = S_RESP;
            end
            S_RESP: begin
                ifu_rsp_valid = !own_lsu;
                lsu_rsp_valid = own_lsu;
                state_nxt     = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            last_ifu    <= 1'b0;
            own_lsu     <= 1'b0;
            addr_q      <= 32'd0;
            wen_q       <= 1'b0;
            wdata_q     <= 32'd0;
            wmask_q     <= 4'd0;
            cnt         <= 16'd0;
            ifu_rdata   <= 32'd0;
            lsu_rdata   <= 32'd0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (grant_ifu || grant_lsu) begin
                        own_lsu  <= grant_lsu;
                        last_ifu <= grant_ifu;
                        addr_q   <= grant_lsu ? lsu_addr : ifu_addr;
                        wen_q    <= grant_lsu && lsu_wen;
                        wdata_q  <= grant_lsu ? lsu_wdata : 32'd0;
                        wmask_q  <= grant_lsu ? lsu_wmask : 4'd0;
                    end
                end
                S_ISSUE: begin
                    if (mem_req_ready)
                        cnt <= CNT_LOAD;
                end
                S_WAIT: begin
                    if (wait_done) begin
                        if (own_lsu)
                            lsu_rdata <= rsp_data;
                        else
                            ifu_rdata <= rsp_data;
                        if (!mem_rsp_valid)
                            timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, checked by a
// scoreboard against a round-robin / timeout reference model.
module tb_mem_arbiter;

    localparam int TO = 8;
    localparam logic [31:0] ERR = 32'hdeadbeef;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        timeout_err;

    mem_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    typedef struct {
        logic        lsu;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          cyc;
    } txn_t;

    typedef struct {
        logic        lsu;
        logic [31:0] rdata;
        int          cyc;
        logic        to;
    } rsp_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    txn_t txn_q[$];
    rsp_t exp_q[$];
    logic grant_log[$];
    txn_t cur;
    rsp_t e;
    logic in_issue = 1'b0;
    logic rsp_prev = 1'b0;
    logic m_last_lsu = 1'b1;
    logic m_to = 1'b0;
    logic exp_l;

    logic        resp_en = 1'b1;
    logic        resp_busy = 1'b0;
    int          force_stall = -1;
    int          force_k = -1;
    logic        use_rdata = 1'b0;
    logic [31:0] force_rdata = 32'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Requester drivers: enter and leave at posedge+1; fields scrambled after the handshake.
    task automatic ifu_req(input logic [31:0] a);
        int n;
        n = 0;
        ifu_addr = a;
        ifu_req_valid = 1'b1;
        #1;
        while (!ifu_req_ready && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 200) begin
            note_fail("ifu_ready_timeout");
            ifu_req_valid = 1'b0;
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            ifu_req_valid = 1'b0;
            ifu_addr = $urandom;
        end
    endtask

    task automatic lsu_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] m);
        int n;
        n = 0;
        lsu_addr = a;
        lsu_wen = w;
        lsu_wdata = d;
        lsu_wmask = m;
        lsu_req_valid = 1'b1;
        #1;
        while (!lsu_req_ready && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 200) begin
            note_fail("lsu_ready_timeout");
            lsu_req_valid = 1'b0;
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            lsu_req_valid = 1'b0;
            lsu_addr = $urandom;
            lsu_wen = 1'($urandom_range(0, 1));
            lsu_wdata = $urandom;
            lsu_wmask = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic lsu_rand();
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic [3:0]  m;
        a = $urandom & 32'hffff_fffc;
        w = 1'($urandom_range(0, 1));
        d = $urandom;
        m = 4'($urandom_range(0, 15));
        lsu_req(a, w, d, m);
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        repeat (2) begin @(posedge clk); #1; end
        while ((exp_q.size() != 0 || txn_q.size() != 0 || resp_busy || in_issue) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) note_fail("quiesce_timeout");
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    // Downstream memory model: random accept stall, then a response after k wait
    // cycles; k beyond TO means no response and a forced error is expected.
    initial begin
        int stall;
        int k;
        logic [31:0] rd;
        txn_t t;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (!resp_en) continue;
            mem_rdata = $urandom;
            mem_rsp_valid = ($urandom_range(0, 7) == 0);
            mem_req_ready = 1'b0;
            if (mem_req_valid && !rst) begin
                resp_busy = 1'b1;
                stall = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
                repeat (stall) begin
                    @(posedge clk); #1;
                    mem_rsp_valid = ($urandom_range(0, 7) == 0);
                    mem_rdata = $urandom;
                end
                mem_req_ready = 1'b1;
                @(posedge clk); #1;
                mem_req_ready = 1'b0;
                mem_rsp_valid = 1'b0;
                t = cur;
                k = (force_k >= 0) ? force_k : int'($urandom_range(1, TO + 2));
                if (k <= TO) begin
                    repeat (k - 1) begin @(posedge clk); #1; mem_rdata = $urandom; end
                    rd = use_rdata ? force_rdata : $urandom;
                    mem_rsp_valid = 1'b1;
                    mem_rdata = rd;
                    exp_q.push_back('{lsu: t.lsu, rdata: (t.wen ? 32'd0 : rd), cyc: cyc + 1, to: 1'b0});
                    @(posedge clk); #1;
                    mem_rsp_valid = 1'b0;
                end else begin
                    exp_q.push_back('{lsu: t.lsu, rdata: (t.wen ? 32'd0 : ERR), cyc: cyc + TO, to: 1'b1});
                    repeat (TO) begin @(posedge clk); #1; mem_rdata = $urandom; end
                end
                resp_busy = 1'b0;
            end
        end
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            m_last_lsu = 1'b1;
            m_to = 1'b0;
            txn_q.delete();
            exp_q.delete();
            in_issue = 1'b0;
            rsp_prev = 1'b0;
        end else begin
            chk("ready_exclusive", 72'(ifu_req_ready & lsu_req_ready), 72'(0));
            chk("ready_without_valid", 72'((ifu_req_ready & ~ifu_req_valid) | (lsu_req_ready & ~lsu_req_valid)), 72'(0));
            if (rsp_prev && (ifu_req_valid || lsu_req_valid))
                chk("accept_after_rsp", 72'(ifu_req_ready | lsu_req_ready), 72'(1));
            if ((ifu_req_ready && ifu_req_valid) || (lsu_req_ready && lsu_req_valid)) begin
                exp_l = lsu_req_valid && (!ifu_req_valid || !m_last_lsu);
                chk("grant_owner", 72'(lsu_req_ready), 72'(exp_l));
                m_last_lsu = exp_l;
                grant_log.push_back(exp_l);
                if (exp_l)
                    txn_q.push_back('{lsu: 1'b1, addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask, cyc: cyc});
                else
                    txn_q.push_back('{lsu: 1'b0, addr: ifu_addr, wen: 1'b0, wdata: 32'd0, wmask: 4'd0, cyc: cyc});
            end

            if (mem_req_valid) begin
                if (!in_issue) begin
                    if (txn_q.size() == 0) begin
                        note_fail("mem_req_unexpected");
                    end else begin
                        cur = txn_q.pop_front();
                        in_issue = 1'b1;
                        chk("mem_req_latency", 72'(cyc), 72'(cur.cyc + 1));
                    end
                end
                if (in_issue)
                    chk("mem_fields", 72'({mem_addr, mem_wen, mem_wdata, mem_wmask}),
                        72'({cur.addr, cur.wen, cur.wdata, cur.wmask}));
                if (mem_req_ready) in_issue = 1'b0;
            end else begin
                chk("mem_idle_zero", 72'({mem_addr, mem_wen, mem_wdata, mem_wmask}), 72'(0));
                if (in_issue) begin
                    note_fail("mem_req_dropped");
                    in_issue = 1'b0;
                end
            end

            rsp_prev = 1'b0;
            chk("rsp_exclusive", 72'(ifu_rsp_valid & lsu_rsp_valid), 72'(0));
            if (ifu_rsp_valid || lsu_rsp_valid) begin
                rsp_prev = 1'b1;
                if (exp_q.size() == 0) begin
                    note_fail("rsp_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_owner", 72'(lsu_rsp_valid), 72'(e.lsu));
                    chk("rsp_cycle", 72'(cyc), 72'(e.cyc));
                    chk("rsp_rdata", 72'(e.lsu ? lsu_rdata : ifu_rdata), 72'(e.rdata));
                    m_to = m_to | e.to;
                    chk("timeout_err", 72'(timeout_err), 72'(m_to));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                note_fail("rsp_missing");
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic exp_order [4];
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = 32'd0;
        lsu_req_valid = 1'b0; lsu_addr = 32'd0; lsu_wen = 1'b0; lsu_wdata = 32'd0; lsu_wmask = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 72'({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
                                  mem_req_valid, timeout_err, mem_wen, mem_wmask}), 72'(0));
        chk("reset_data", 72'({ifu_rdata, lsu_rdata}), 72'(0));
        chk("reset_mem", 72'({mem_addr, mem_wdata}), 72'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // single fetch, immediate accept and response
        force_stall = 0; force_k = 1; use_rdata = 1'b1; force_rdata = 32'h0000_0413;
        ifu_req(32'h8000_0000);
        wait_quiet();

        // store with a 3-cycle downstream stall
        force_stall = 3; force_k = -1; use_rdata = 1'b0;
        lsu_req(32'h8000_1000, 1'b1, 32'h1234_5678, 4'b0011);
        wait_quiet();

        // response on the last wait cycle beats the timeout
        force_stall = 0; force_k = TO; use_rdata = 1'b1; force_rdata = 32'hcafe_f00d;
        lsu_req(32'h8000_2000, 1'b0, 32'd0, 4'd0);
        wait_quiet();
        chk("no_timeout_at_boundary", 72'(timeout_err), 72'(0));

        // contention right after reset
        apply_reset();
        force_stall = -1; force_k = 1; use_rdata = 1'b0;
        grant_log.delete();
        fork
            begin ifu_req(32'h8000_0010); ifu_req(32'h8000_0014); end
            begin lsu_rand(); lsu_rand(); end
        join
        wait_quiet();
        if (grant_log.size() < 4) begin
            note_fail("grant_order_count");
        end else begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("grant_order_%0d", i), 72'(grant_log[i]), 72'(exp_order[i]));
        end

        // timeout on a read, then a normal transaction keeps the sticky flag
        force_stall = 0; force_k = TO + 1;
        lsu_req(32'h8000_3000, 1'b0, 32'd0, 4'd0);
        wait_quiet();
        chk("timeout_sticky", 72'(timeout_err), 72'(1));
        force_k = 1;
        ifu_req(32'h8000_0020);
        wait_quiet();

        // randomized traffic
        force_stall = -1; force_k = -1;
        fork
            repeat (40) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                ifu_req($urandom & 32'hffff_fffc);
            end
            repeat (40) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                lsu_rand();
            end
        join
        wait_quiet();

        // reset while waiting for a response
        resp_en = 1'b0;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        lsu_req(32'h8000_4000, 1'b0, 32'd0, 4'd0);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h1111_1111;
        ifu_addr = 32'h8000_0100;
        ifu_req_valid = 1'b1;
        #1;
        chk("ready_after_reset", 72'(ifu_req_ready), 72'(1));
        chk("timeout_err_reset", 72'(timeout_err), 72'(0));
        chk("no_rsp_after_reset", 72'({ifu_rsp_valid, lsu_rsp_valid}), 72'(0));
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        mem_rsp_valid = 1'b0;
        force_stall = 0; force_k = 1;
        resp_en = 1'b1;
        wait_quiet();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
